uart_prog_loader: RTL and testbench

UART_PROG_LOADER -- requirements
Module: uart_prog_loader

---
 rtl/uart_prog_loader_if.sv | 27 ++
 rtl/uart_prog_loader.sv | 168 ++++++++++++++++
 tb/tb_uart_prog_loader.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_prog_loader_if.sv
// Bus bundle for uart_prog_loader: UART rx/tx byte streams, memory write port, boot jump and status.
// The slave modport is the loader's view; the master modport is the surrounding system's view.
interface uart_prog_loader_if;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_we;
  logic        mem_ack;
  logic [31:0] boot_pc;
  logic        boot_go;
  logic        busy;
  logic        overrun;

  modport slave (
    input  rx_data, rx_valid, tx_ready, mem_ack,
    output tx_data, tx_valid, mem_addr, mem_wdata, mem_we, boot_pc, boot_go, busy, overrun
  );

  modport master (
    output rx_data, rx_valid, tx_ready, mem_ack,
    input  tx_data, tx_valid, mem_addr, mem_wdata, mem_we, boot_pc, boot_go, busy, overrun
  );
endinterface

// File: rtl/uart_prog_loader.sv
// Byte-command program loader: 'o' sets the load pointer, 'd' writes a word, 'i' sends the ID, 'j' jumps.
// Optional macro PROG_LOADER_ACK_EN: each completed write is acknowledged by transmitting '.'.
module uart_prog_loader #(
  parameter logic [31:0] ID_WORD    = 32'h504C502D,
  parameter logic [31:0] RESET_ADDR = 32'h10000000
) (
  input  logic              clk,
  input  logic              rst_n,
  uart_prog_loader_if.slave bus
);
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ADDR  = 3'd1,
    DATA  = 3'd2,
    WRITE = 3'd3,
    IDTX  = 3'd4,
`ifdef PROG_LOADER_ACK_EN
    JUMP  = 3'd5,
    ACKTX = 3'd6
`else
    JUMP  = 3'd5
`endif
  } state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic [1:0]  r_cnt;
  logic [23:0] r_word;
  logic [31:0] r_ptr;
  logic [7:0]  r_tx_data;
  logic        r_tx_valid;
  logic [31:0] r_mem_addr;
  logic [31:0] r_mem_wdata;
  logic        r_mem_we;
  logic [31:0] r_boot_pc;
  logic        r_boot_go;
  logic        r_overrun;

  logic [31:0] w_word;
  logic        w_tx_fire;
  logic        w_drop;
  logic [7:0]  w_id_next;

  // The fourth byte of a field is combined straight from rx_data, so only three bytes are stored.
  assign w_word    = {r_word, bus.rx_data};
  assign w_tx_fire = r_tx_valid && bus.tx_ready;
  assign w_drop    = bus.rx_valid && (r_state != IDLE) && (r_state != ADDR) && (r_state != DATA);

  always_comb begin
    w_id_next = ID_WORD[7:0];
    case (r_cnt)
      2'd0:    w_id_next = ID_WORD[23:16];
      2'd1:    w_id_next = ID_WORD[15:8];
      default: w_id_next = ID_WORD[7:0];
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE: begin
        if (bus.rx_valid) begin
          case (bus.rx_data)
            8'h6F:   w_state_next = ADDR;
            8'h64:   w_state_next = DATA;
            8'h69:   w_state_next = IDTX;
            8'h6A:   w_state_next = JUMP;
            default: w_state_next = IDLE;
          endcase
        end
      end
      ADDR:  if (bus.rx_valid && r_cnt == 2'd3) w_state_next = IDLE;
      DATA:  if (bus.rx_valid && r_cnt == 2'd3) w_state_next = WRITE;
`ifdef PROG_LOADER_ACK_EN
      WRITE: if (bus.mem_ack) w_state_next = ACKTX;
      ACKTX: if (w_tx_fire) w_state_next = IDLE;
`else
      WRITE: if (bus.mem_ack) w_state_next = IDLE;
`endif
      IDTX:  if (w_tx_fire && r_cnt == 2'd3) w_state_next = IDLE;
      JUMP:  w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt       <= 2'd0;
      r_word      <= 24'd0;
      r_ptr       <= RESET_ADDR;
      r_tx_data   <= 8'd0;
      r_tx_valid  <= 1'b0;
      r_mem_addr  <= 32'd0;
      r_mem_wdata <= 32'd0;
      r_mem_we    <= 1'b0;
      r_boot_pc   <= 32'd0;
      r_boot_go   <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_boot_go <= 1'b0;
      if (w_drop) r_overrun <= 1'b1;
      case (r_state)
        IDLE: begin
          r_cnt <= 2'd0;
          if (bus.rx_valid && bus.rx_data == 8'h69) begin
            r_tx_valid <= 1'b1;
            r_tx_data  <= ID_WORD[31:24];
          end
        end
        ADDR, DATA: begin
          if (bus.rx_valid) begin
            r_cnt  <= r_cnt + 2'd1;
            r_word <= {r_word[15:0], bus.rx_data};
            if (r_cnt == 2'd3) begin
              if (r_state == ADDR) begin
                r_ptr <= {w_word[31:2], 2'b00};
              end else begin
                r_mem_we    <= 1'b1;
                r_mem_addr  <= r_ptr;
                r_mem_wdata <= w_word;
              end
            end
          end
        end
        WRITE: begin
          if (bus.mem_ack) begin
            r_mem_we <= 1'b0;
            r_ptr    <= r_ptr + 32'd4;
`ifdef PROG_LOADER_ACK_EN
            r_tx_valid <= 1'b1;
            r_tx_data  <= 8'h2E;
`endif
          end
        end
        IDTX: begin
          if (w_tx_fire) begin
            r_cnt <= r_cnt + 2'd1;
            if (r_cnt == 2'd3) r_tx_valid <= 1'b0;
            else               r_tx_data  <= w_id_next;
          end
        end
        JUMP: begin
          r_boot_go <= 1'b1;
          r_boot_pc <= r_ptr;
        end
`ifdef PROG_LOADER_ACK_EN
        ACKTX: if (w_tx_fire) r_tx_valid <= 1'b0;
`endif
        default: ;
      endcase
    end
  end

  assign bus.tx_data   = r_tx_data;
  assign bus.tx_valid  = r_tx_valid;
  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_wdata = r_mem_wdata;
  assign bus.mem_we    = r_mem_we;
  assign bus.boot_pc   = r_boot_pc;
  assign bus.boot_go   = r_boot_go;
  assign bus.busy      = (r_state != IDLE);
  assign bus.overrun   = r_overrun;
endmodule

// File: tb/tb_uart_prog_loader.sv
// Directed bench for uart_prog_loader: table of command records plus hand-written corner sequences.
// A negedge monitor collects tx handshakes, memory writes and boot pulses into queues for checking.
module tb_uart_prog_loader;
  logic clk;
  logic rst_n;
  uart_prog_loader_if bus();

  uart_prog_loader dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef enum {OP_ID, OP_ADDR, OP_WRITE, OP_JUMP, OP_JUNK} op_t;
  typedef struct {
    op_t         op;
    logic [31:0] arg;
    logic [31:0] exp_a;
    logic [31:0] exp_b;
  } vec_t;

  int errors = 0;
  int checks = 0;

  logic [7:0]  txq[$];
  logic [31:0] wq_addr[$];
  logic [31:0] wq_data[$];
  logic [31:0] goq_pc[$];
  int          goq_len[$];
  int          go_len = 0;
  logic [31:0] go_pc = 32'd0;

  always begin
    @(negedge clk);
    #1;
    if (bus.mem_we && bus.mem_ack) begin
      wq_addr.push_back(bus.mem_addr);
      wq_data.push_back(bus.mem_wdata);
    end
    if (bus.tx_valid && bus.tx_ready) txq.push_back(bus.tx_data);
    if (bus.boot_go) begin
      go_len++;
      go_pc = bus.boot_pc;
    end else if (go_len != 0) begin
      goq_pc.push_back(go_pc);
      goq_len.push_back(go_len);
      go_len = 0;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end else begin
      $display("ok   %s: 0x%08h", name, act);
    end
  endtask

  task automatic clear_queues();
    txq.delete();
    wq_addr.delete();
    wq_data.delete();
    goq_pc.delete();
    goq_len.delete();
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
  endtask

  task automatic rx_done();
    @(negedge clk);
    bus.rx_valid = 1'b0;
    #2;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 3; i >= 0; i--) send_byte(w[8*i +: 8]);
  endtask

  function automatic logic [31:0] tx_at(input int i);
    return (txq.size() > i) ? 32'(txq[i]) : 32'hDEAD0000;
  endfunction

  task automatic run_op(input vec_t v);
    int exp_tx;
    clear_queues();
    case (v.op)
      OP_ID:    send_byte(8'h69);
      OP_ADDR:  begin send_byte(8'h6F); send_word(v.arg); end
      OP_WRITE: begin send_byte(8'h64); send_word(v.arg); end
      OP_JUMP:  send_byte(8'h6A);
      default:  send_byte(v.arg[7:0]);
    endcase
    rx_done();
    repeat (30) @(negedge clk);
    #2;
    exp_tx = (v.op == OP_ID) ? 4 : 0;
`ifdef PROG_LOADER_ACK_EN
    if (v.op == OP_WRITE) exp_tx = 1;
`endif
    chk($sformatf("%s tx_count", v.op.name()), 32'(txq.size()), 32'(exp_tx));
    chk($sformatf("%s write_count", v.op.name()), 32'(wq_addr.size()), (v.op == OP_WRITE) ? 32'd1 : 32'd0);
    chk($sformatf("%s jump_count", v.op.name()), 32'(goq_pc.size()), (v.op == OP_JUMP) ? 32'd1 : 32'd0);
    chk($sformatf("%s busy_after", v.op.name()), 32'(bus.busy), 32'd0);
    if (v.op == OP_ID) begin
      for (int i = 0; i < 4; i++)
        chk($sformatf("id_byte%0d", i), tx_at(i), 32'(v.exp_a[8*(3-i) +: 8]));
    end
    if (v.op == OP_WRITE && wq_addr.size() > 0) begin
      chk("write_addr", wq_addr[0], v.exp_a);
      chk("write_data", wq_data[0], v.exp_b);
`ifdef PROG_LOADER_ACK_EN
      chk("write_ack_byte", tx_at(0), 32'h2E);
`endif
    end
    if (v.op == OP_JUMP && goq_pc.size() > 0) begin
      chk("boot_pc", goq_pc[0], v.exp_a);
      chk("boot_go_len", 32'(goq_len[0]), 32'd1);
    end
  endtask

  vec_t vecs[11];

  initial begin
    vecs[0]  = '{OP_JUMP,  32'h0,        32'h10000000, 32'h0};
    vecs[1]  = '{OP_ID,    32'h0,        32'h504C502D, 32'h0};
    vecs[2]  = '{OP_ADDR,  32'h00000102, 32'h0,        32'h0};
    vecs[3]  = '{OP_WRITE, 32'hDEADBEEF, 32'h00000100, 32'hDEADBEEF};
    vecs[4]  = '{OP_WRITE, 32'h01234567, 32'h00000104, 32'h01234567};
    vecs[5]  = '{OP_JUMP,  32'h0,        32'h00000108, 32'h0};
    vecs[6]  = '{OP_JUNK,  32'h00000000, 32'h0,        32'h0};
    vecs[7]  = '{OP_ADDR,  32'hFFFFFFFF, 32'h0,        32'h0};
    vecs[8]  = '{OP_WRITE, 32'hA5A5A5A5, 32'hFFFFFFFC, 32'hA5A5A5A5};
    vecs[9]  = '{OP_WRITE, 32'h5A5A5A5A, 32'h00000000, 32'h5A5A5A5A};
    vecs[10] = '{OP_JUMP,  32'h0,        32'h00000004, 32'h0};

    rst_n        = 1'b0;
    bus.rx_data  = 8'h00;
    bus.rx_valid = 1'b0;
    bus.tx_ready = 1'b1;
    bus.mem_ack  = 1'b1;
    repeat (3) @(negedge clk);
    #2;
    chk("rst tx_valid",  32'(bus.tx_valid), 32'd0);
    chk("rst tx_data",   32'(bus.tx_data),  32'd0);
    chk("rst mem_we",    32'(bus.mem_we),   32'd0);
    chk("rst mem_addr",  bus.mem_addr,      32'd0);
    chk("rst mem_wdata", bus.mem_wdata,     32'd0);
    chk("rst boot_go",   32'(bus.boot_go),  32'd0);
    chk("rst boot_pc",   bus.boot_pc,       32'd0);
    chk("rst busy",      32'(bus.busy),     32'd0);
    chk("rst overrun",   32'(bus.overrun),  32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 11; i++) run_op(vecs[i]);

    // Byte arriving while a write is stalled: dropped, flagged, write untouched.
    clear_queues();
    @(negedge clk);
    bus.mem_ack = 1'b0;
    send_byte(8'h64);
    send_word(32'h11223344);
    rx_done();
    chk("stall mem_we",    32'(bus.mem_we), 32'd1);
    chk("stall mem_addr",  bus.mem_addr,    32'h00000004);
    chk("stall mem_wdata", bus.mem_wdata,   32'h11223344);
    send_byte(8'h55);
    rx_done();
    chk("overrun set",       32'(bus.overrun), 32'd1);
    chk("stall hold we",     32'(bus.mem_we),  32'd1);
    chk("stall hold addr",   bus.mem_addr,     32'h00000004);
    chk("stall hold wdata",  bus.mem_wdata,    32'h11223344);
    repeat (3) @(negedge clk);
    bus.mem_ack = 1'b1;
    repeat (20) @(negedge clk);
    #2;
    chk("stall write_count", 32'(wq_addr.size()), 32'd1);
    if (wq_addr.size() > 0) begin
      chk("stall write_addr", wq_addr[0], 32'h00000004);
      chk("stall write_data", wq_data[0], 32'h11223344);
    end
    chk("stall we_dropped", 32'(bus.mem_we), 32'd0);

    // ID transmit held off by tx_ready for 10 cycles.
    clear_queues();
    @(negedge clk);
    bus.tx_ready = 1'b0;
    send_byte(8'h69);
    rx_done();
    for (int c = 0; c < 10; c++) begin
      chk($sformatf("txhold c%0d", c), {23'd0, bus.tx_valid, bus.tx_data}, 32'h150);
      @(negedge clk);
      #2;
    end
    chk("overrun sticky", 32'(bus.overrun), 32'd1);
    @(negedge clk);
    bus.tx_ready = 1'b1;
    repeat (20) @(negedge clk);
    #2;
    chk("txhold count", 32'(txq.size()), 32'd4);
    chk("txhold byte0", tx_at(0), 32'h50);
    chk("txhold byte3", tx_at(3), 32'h2D);
    chk("txhold busy",  32'(bus.busy), 32'd0);

    // Unknown byte ignored, then reset in the middle of the ID transfer.
    clear_queues();
    send_byte(8'h41);
    rx_done();
    chk("junk busy", 32'(bus.busy), 32'd0);
    send_byte(8'h69);
    rx_done();
    for (int c = 0; c < 20 && txq.size() < 2; c++) begin
      @(negedge clk);
      #2;
    end
    chk("mid id bytes seen", 32'(txq.size()), 32'd2);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("mid rst tx_valid", 32'(bus.tx_valid), 32'd0);
    chk("mid rst busy",     32'(bus.busy),     32'd0);
    chk("mid rst overrun",  32'(bus.overrun),  32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    #2;
    chk("mid rst tx_count", 32'(txq.size()), 32'd2);
    chk("mid rst byte0",    tx_at(0), 32'h50);
    chk("mid rst byte1",    tx_at(1), 32'h4C);
    chk("mid rst tx_quiet", 32'(bus.tx_valid), 32'd0);

    run_op('{OP_JUMP, 32'h0, 32'h10000000, 32'h0});

    // Partial address field waits indefinitely for its remaining bytes.
    send_byte(8'h6F);
    send_byte(8'h00);
    send_byte(8'h00);
    rx_done();
    repeat (20) @(negedge clk);
    #2;
    chk("partial busy", 32'(bus.busy), 32'd1);
    send_byte(8'h02);
    send_byte(8'h03);
    rx_done();
    chk("partial done busy", 32'(bus.busy), 32'd0);
    run_op('{OP_WRITE, 32'hCAFEF00D, 32'h00000200, 32'hCAFEF00D});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
